// File: rtl/pipe_ctrl_pkg.sv
// Shared pipeline-control types: controller FSM states, pipeline-register
// indices and the per-register stall/flush bundle fanned out to the stages.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        HALT  = 2'd2
    } ctrl_state_e;

    localparam int NUM_REGS  = 4;
    localparam int REG_IFID  = 0;
    localparam int REG_IDEX  = 1;
    localparam int REG_EXMEM = 2;
    localparam int REG_MEMWB = 3;

    typedef struct packed {
        logic                pc_stall;
        logic [NUM_REGS-1:0] stall;
        logic [NUM_REGS-1:0] flush;
    } pipe_control_t;

    function automatic pipe_control_t mk_ctrl(input logic                pc_stall,
                                              input logic [NUM_REGS-1:0] stall,
                                              input logic [NUM_REGS-1:0] flush);
        pipe_control_t c;
        c.pc_stall = pc_stall;
        c.stall    = stall;
        c.flush    = flush;
        return c;
    endfunction

    localparam pipe_control_t CTRL_NONE     = mk_ctrl(1'b0, 4'b0000, 4'b0000);
    localparam pipe_control_t CTRL_RESET    = mk_ctrl(1'b0, 4'b0000, 4'b1111);
    localparam pipe_control_t CTRL_HALT     = mk_ctrl(1'b1, 4'b1111, 4'b0000);
    // Hold everything up to MEM, drop a bubble into WB.
    localparam pipe_control_t CTRL_MEM_WAIT = mk_ctrl(1'b1, 4'b0111, 4'b1000);
    localparam pipe_control_t CTRL_REDIRECT = mk_ctrl(1'b0, 4'b0000, 4'b0011);
    localparam pipe_control_t CTRL_ID_BUB   = mk_ctrl(1'b1, 4'b0001, 4'b0010);
    localparam pipe_control_t CTRL_IF_BUB   = mk_ctrl(1'b1, 4'b0000, 4'b0001);

endpackage

// File: rtl/pipe_ctrl_hazard_detect.sv
// Load-use hazard compare between the load in EX and the consumer in ID.
// Purely combinational so the forwarding unit can reuse it.
module hazard_detect (
    input  logic       ex_valid_i,
    input  logic       ex_mem_read_i,
    input  logic [4:0] ex_rd_i,
    input  logic       id_valid_i,
    input  logic [4:0] id_rs1_i,
    input  logic [4:0] id_rs2_i,
    input  logic       id_uses_rs1_i,
    input  logic       id_uses_rs2_i,
    output logic       load_use_o
);

    logic rs1_hit;
    logic rs2_hit;

    // x0 is hardwired to zero, so a load targeting it never creates a hazard.
    assign rs1_hit    = id_uses_rs1_i && (id_rs1_i == ex_rd_i);
    assign rs2_hit    = id_uses_rs2_i && (id_rs2_i == ex_rd_i);
    assign load_use_o = ex_valid_i && ex_mem_read_i && (ex_rd_i != 5'd0) &&
                        id_valid_i && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipe_ctrl.sv
// Central pipeline controller: priority resolution of hazards into
// stall/flush controls, decode-error drain/halt FSM and perf counters.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int DRAIN_CYCLES = 3,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       stage_stall_req,
    input  logic             id_valid,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic             id_error,
    input  logic             ex_valid,
    input  logic [4:0]       ex_rd,
    input  logic             ex_mem_read,
    input  logic             ex_redirect,
    input  logic             mem_busy,
    output logic             pc_stall,
    output logic [3:0]       stall,
    output logic [3:0]       flush,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] redirect_count
);

    localparam int DCNT_W = $clog2(DRAIN_CYCLES + 1);

    ctrl_state_e       state_q, state_d;
    logic [DCNT_W-1:0] drain_cnt_q, drain_cnt_d;
    logic [CNT_W-1:0]  stall_cycles_q, stall_cycles_d;
    logic [CNT_W-1:0]  redirect_count_q, redirect_count_d;

    pipe_control_t ctrl;
    logic          load_use;
    logic          id_err;
    logic          redirect_fire;

    hazard_detect u_hazard (
        .ex_valid_i    (ex_valid),
        .ex_mem_read_i (ex_mem_read),
        .ex_rd_i       (ex_rd),
        .id_valid_i    (id_valid),
        .id_rs1_i      (id_rs1),
        .id_rs2_i      (id_rs2),
        .id_uses_rs1_i (id_uses_rs1),
        .id_uses_rs2_i (id_uses_rs2),
        .load_use_o    (load_use)
    );

    assign id_err = (state_q == RUN) && id_valid && id_error;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        ctrl          = CTRL_NONE;
        redirect_fire = 1'b0;
        if (rst) begin
            ctrl = CTRL_RESET;
        end else if (state_q == HALT) begin
            ctrl = CTRL_HALT;
        end else if (mem_busy) begin
            ctrl = CTRL_MEM_WAIT;
        end else if (ex_redirect) begin
            ctrl          = CTRL_REDIRECT;
            redirect_fire = 1'b1;
        end else if (load_use || (state_q == DRAIN) || id_err || stage_stall_req[1]) begin
            ctrl = CTRL_ID_BUB;
        end else if (stage_stall_req[0]) begin
            ctrl = CTRL_IF_BUB;
        end
    end

    // An error masked by a higher-priority rule is simply seen again next cycle.
    always_comb begin
        state_d     = state_q;
        drain_cnt_d = drain_cnt_q;
        case (state_q)
            RUN: begin
                if (id_err && !mem_busy && !ex_redirect && !load_use) begin
                    state_d     = DRAIN;
                    drain_cnt_d = DCNT_W'(DRAIN_CYCLES);
                end
            end
            DRAIN: begin
                if (!mem_busy) begin
                    if (ex_redirect) begin
                        state_d     = RUN;
                        drain_cnt_d = '0;
                    end else begin
                        drain_cnt_d = drain_cnt_q - DCNT_W'(1);
                        if (drain_cnt_q == DCNT_W'(1)) begin
                            state_d = HALT;
                        end
                    end
                end
            end
            HALT:    state_d = HALT;
            default: state_d = RUN;
        endcase
    end

    always_comb begin
        stall_cycles_d   = stall_cycles_q;
        redirect_count_d = redirect_count_q;
        if (ctrl.pc_stall && (state_q != HALT)) begin
            stall_cycles_d = stall_cycles_q + CNT_W'(1);
        end
        if (redirect_fire) begin
            redirect_count_d = redirect_count_q + CNT_W'(1);
        end
    end

    // NOTE: reset is synchronous, so it is sampled inside the clocked branch only.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= RUN;
            drain_cnt_q      <= '0;
            stall_cycles_q   <= '0;
            redirect_count_q <= '0;
        end else begin
            state_q          <= state_d;
            drain_cnt_q      <= drain_cnt_d;
            stall_cycles_q   <= stall_cycles_d;
            redirect_count_q <= redirect_count_d;
        end
    end

    assign pc_stall       = ctrl.pc_stall;
    assign stall          = ctrl.stall;
    assign flush          = ctrl.flush;
    assign halted         = (state_q == HALT);
    assign stall_cycles   = stall_cycles_q;
    assign redirect_count = redirect_count_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed hazard scenarios plus random
// traffic compared every cycle against a rule-level reference model.
module tb_pipe_ctrl;

    localparam int DRAIN_CYCLES = 3;
    localparam int CNT_W        = 32;

    logic             clk;
    logic             rst;
    logic [1:0]       stage_stall_req;
    logic             id_valid;
    logic [4:0]       id_rs1;
    logic [4:0]       id_rs2;
    logic             id_uses_rs1;
    logic             id_uses_rs2;
    logic             id_error;
    logic             ex_valid;
    logic [4:0]       ex_rd;
    logic             ex_mem_read;
    logic             ex_redirect;
    logic             mem_busy;
    logic             pc_stall;
    logic [3:0]       stall;
    logic [3:0]       flush;
    logic             halted;
    logic [CNT_W-1:0] stall_cycles;
    logic [CNT_W-1:0] redirect_count;

    pipe_ctrl #(.DRAIN_CYCLES(DRAIN_CYCLES), .CNT_W(CNT_W)) dut (
        .clk             (clk),
        .rst             (rst),
        .stage_stall_req (stage_stall_req),
        .id_valid        (id_valid),
        .id_rs1          (id_rs1),
        .id_rs2          (id_rs2),
        .id_uses_rs1     (id_uses_rs1),
        .id_uses_rs2     (id_uses_rs2),
        .id_error        (id_error),
        .ex_valid        (ex_valid),
        .ex_rd           (ex_rd),
        .ex_mem_read     (ex_mem_read),
        .ex_redirect     (ex_redirect),
        .mem_busy        (mem_busy),
        .pc_stall        (pc_stall),
        .stall           (stall),
        .flush           (flush),
        .halted          (halted),
        .stall_cycles    (stall_cycles),
        .redirect_count  (redirect_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: halted flag, retire cycles left while draining, counters.
    bit               m_halted;
    int               m_drain_left;
    logic [CNT_W-1:0] m_stall_cycles;
    logic [CNT_W-1:0] m_redirects;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit m_load_use();
        bit hit;
        hit = (id_uses_rs1 && id_rs1 == ex_rd) || (id_uses_rs2 && id_rs2 == ex_rd);
        return ex_valid && ex_mem_read && (ex_rd != 5'd0) && id_valid && hit;
    endfunction

    // Expected {pc_stall, stall, flush} from the priority rules.
    function automatic logic [8:0] m_ctrl();
        if (rst)                      return {1'b0, 4'b0000, 4'b1111};
        if (m_halted)                 return {1'b1, 4'b1111, 4'b0000};
        if (mem_busy)                 return {1'b1, 4'b0111, 4'b1000};
        if (ex_redirect)              return {1'b0, 4'b0000, 4'b0011};
        if (m_load_use())             return {1'b1, 4'b0001, 4'b0010};
        if (m_drain_left > 0)         return {1'b1, 4'b0001, 4'b0010};
        if (id_valid && id_error)     return {1'b1, 4'b0001, 4'b0010};
        if (stage_stall_req[1])       return {1'b1, 4'b0001, 4'b0010};
        if (stage_stall_req[0])       return {1'b1, 4'b0000, 4'b0001};
        return 9'd0;
    endfunction

    task automatic model_edge();
        logic [8:0] e;
        e = m_ctrl();
        if (rst) begin
            m_halted       = 1'b0;
            m_drain_left   = 0;
            m_stall_cycles = '0;
            m_redirects    = '0;
        end else if (!m_halted) begin
            if (e[8]) m_stall_cycles = m_stall_cycles + 1'b1;
            if (!mem_busy && ex_redirect) m_redirects = m_redirects + 1'b1;
            if (m_drain_left > 0) begin
                if (!mem_busy) begin
                    if (ex_redirect)            m_drain_left = 0;
                    else if (m_drain_left == 1) begin m_drain_left = 0; m_halted = 1'b1; end
                    else                        m_drain_left--;
                end
            end else if (id_valid && id_error && !mem_busy && !ex_redirect && !m_load_use()) begin
                m_drain_left = DRAIN_CYCLES;
            end
        end
    endtask

    // Compare at the falling edge, advance the model, return just after the rising edge.
    task automatic step();
        logic [8:0] e;
        @(negedge clk);
        e = m_ctrl();
        check("pc_stall", {31'd0, pc_stall}, {31'd0, e[8]});
        check("stall", {28'd0, stall}, {28'd0, e[7:4]});
        check("flush", {28'd0, flush}, {28'd0, e[3:0]});
        check("stall_and_flush", {28'd0, stall & flush}, 32'd0);
        check("halted", {31'd0, halted}, {31'd0, m_halted});
        check("stall_cycles", stall_cycles, m_stall_cycles);
        check("redirect_count", redirect_count, m_redirects);
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rst = 0; stage_stall_req = 2'b00; id_valid = 0; id_rs1 = 0; id_rs2 = 0;
        id_uses_rs1 = 0; id_uses_rs2 = 0; id_error = 0; ex_valid = 0; ex_rd = 0;
        ex_mem_read = 0; ex_redirect = 0; mem_busy = 0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1;
        step();
        rst = 0;
    endtask

    task automatic expect_ctrl(input string tag, input logic p, input logic [3:0] s, input logic [3:0] f);
        #1;
        check({tag, "_pc"}, {31'd0, pc_stall}, {31'd0, p});
        check({tag, "_stall"}, {28'd0, stall}, {28'd0, s});
        check({tag, "_flush"}, {28'd0, flush}, {28'd0, f});
    endtask

    task automatic load_use_setup(input logic [4:0] rd);
        ex_valid = 1; ex_mem_read = 1; ex_rd = rd;
        id_valid = 1; id_rs1 = 5'd5; id_uses_rs1 = 1; id_rs2 = 5'd1; id_uses_rs2 = 1;
    endtask

    initial begin
        idle();
        rst = 1;
        m_halted = 0; m_drain_left = 0; m_stall_cycles = '0; m_redirects = '0;
        @(posedge clk);
        #1;
        expect_ctrl("reset", 1'b0, 4'b0000, 4'b1111);
        check("reset_halted", {31'd0, halted}, 32'd0);
        check("reset_stall_cycles", stall_cycles, 32'd0);
        check("reset_redirect_count", redirect_count, 32'd0);
        step();
        rst = 0;

        // Load-use: lw x5 in EX, add x6,x5,x1 in ID -> exactly one bubble.
        load_use_setup(5'd5);
        expect_ctrl("lu_bubble", 1'b1, 4'b0001, 4'b0010);
        step();
        ex_valid = 0; ex_mem_read = 0;
        expect_ctrl("lu_after", 1'b0, 4'b0000, 4'b0000);
        step();
        check("lu_stall_cycles", stall_cycles, 32'd1);
        do_reset();
        load_use_setup(5'd0);
        id_rs1 = 5'd0;
        expect_ctrl("lu_x0", 1'b0, 4'b0000, 4'b0000);
        step();

        // Single redirect pulse.
        do_reset();
        ex_redirect = 1;
        expect_ctrl("redir", 1'b0, 4'b0000, 4'b0011);
        step();
        ex_redirect = 0;
        step();
        check("redir_count", redirect_count, 32'd1);

        // Redirect held through three mem_busy cycles is accepted once.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            mem_busy = 1; ex_redirect = 1;
            expect_ctrl("membusy", 1'b1, 4'b0111, 4'b1000);
            step();
        end
        mem_busy = 0;
        expect_ctrl("redir_deferred", 1'b0, 4'b0000, 4'b0011);
        step();
        ex_redirect = 0;
        step();
        check("redir_deferred_count", redirect_count, 32'd1);

        // Decode error drains for DRAIN_CYCLES then halts.
        do_reset();
        id_valid = 1; id_error = 1;
        step();
        id_valid = 0; id_error = 0;
        for (int i = 0; i < DRAIN_CYCLES; i++) begin
            expect_ctrl("drain", 1'b1, 4'b0001, 4'b0010);
            check("drain_not_halted", {31'd0, halted}, 32'd0);
            step();
        end
        check("halt_reached", {31'd0, halted}, 32'd1);
        expect_ctrl("halt", 1'b1, 4'b1111, 4'b0000);
        step();

        // Reset out of HALT.
        rst = 1;
        step();
        rst = 0;
        check("rst_halt_halted", {31'd0, halted}, 32'd0);
        check("rst_halt_stall_cycles", stall_cycles, 32'd0);
        check("rst_halt_redirects", redirect_count, 32'd0);
        expect_ctrl("rst_halt_run", 1'b0, 4'b0000, 4'b0000);
        step();

        // Decode error with two mem_busy cycles inside DRAIN: halt two cycles later.
        id_valid = 1; id_error = 1;
        step();
        id_valid = 0; id_error = 0;
        for (int i = 0; i < DRAIN_CYCLES + 2; i++) begin
            mem_busy = (i == 1 || i == 2);
            check("drain_busy_not_halted", {31'd0, halted}, 32'd0);
            step();
        end
        mem_busy = 0;
        check("drain_busy_halted", {31'd0, halted}, 32'd1);

        // Decode error, then redirect in the second DRAIN cycle: back to RUN.
        do_reset();
        id_valid = 1; id_error = 1;
        step();
        id_valid = 0; id_error = 0;
        step();
        ex_redirect = 1;
        expect_ctrl("drain_redir", 1'b0, 4'b0000, 4'b0011);
        step();
        ex_redirect = 0;
        for (int i = 0; i < DRAIN_CYCLES + 1; i++) begin
            expect_ctrl("drain_redir_run", 1'b0, 4'b0000, 4'b0000);
            step();
        end
        check("drain_redir_halted", {31'd0, halted}, 32'd0);

        // Random traffic against the model.
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            rst             = ($urandom_range(0, 149) == 0) || (m_halted && $urandom_range(0, 7) == 0);
            stage_stall_req = 2'($urandom_range(0, 3) & ($urandom_range(0, 2) == 0 ? 3 : 0));
            id_valid        = $urandom_range(0, 3) != 0;
            id_rs1          = 5'($urandom_range(0, 3));
            id_rs2          = 5'($urandom_range(0, 3));
            id_uses_rs1     = 1'($urandom_range(0, 1));
            id_uses_rs2     = 1'($urandom_range(0, 1));
            id_error        = $urandom_range(0, 24) == 0;
            ex_valid        = $urandom_range(0, 3) != 0;
            ex_rd           = 5'($urandom_range(0, 3));
            ex_mem_read     = 1'($urandom_range(0, 1));
            ex_redirect     = $urandom_range(0, 7) == 0;
            mem_busy        = $urandom_range(0, 4) == 0;
            step();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
